// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the fifo block and its drain engine
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  localparam int DRAIN_BUF_DEPTH = 3;
  localparam int DRAIN_CNT_WIDTH = 16;

  function automatic logic [1:0] drain_ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'(DRAIN_BUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_drain_if.sv
// rtl/fifo_drain_if.sv - fifo read port plus valid/ready output stream of the drain engine
interface fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic                  fifo_thr_trig;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_thr_trig,
    input  fifo_rd_data,
    input  m_ready,
    output fifo_rd,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_thr_trig,
    output fifo_rd_data,
    output m_ready,
    input  fifo_rd,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/fifo_drain_skid_buf.sv
// rtl/fifo_drain_skid_buf.sv - 3-entry circular buffer absorbing fifo read latency and backpressure
module drain_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [DRAIN_BUF_DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
      for (int i = 0; i < DRAIN_BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= drain_ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= drain_ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - drains the fifo in threshold-triggered bursts or full flushes onto a valid/ready stream
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  fifo_drain_if.master               bus,
  output logic                       busy,
  output logic                       done,
  output logic [DRAIN_CNT_WIDTH-1:0] words_sent
);

  drain_state_t          state;
  logic [7:0]            issue_cnt;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  active;
  logic                  rd;
  logic                  pop;
  logic                  room;
  logic                  nothing_to_issue;
  logic                  buf_drains;
  logic                  finish;

  assign active = (state != IDLE);
  assign busy   = active;

  // Room counts the word already in flight so the buffer can never overflow.
  assign room = ({1'b0, buf_count} + {2'b00, inflight}) < 3'(DRAIN_BUF_DEPTH);
  assign rd   = active && en && !bus.fifo_empty && room &&
                ((state == FLUSH) || (issue_cnt != 8'd0));

  assign bus.fifo_rd = rd;
  assign bus.m_valid = (buf_count != 2'd0);
  assign bus.m_data  = head_data;
  assign pop         = bus.m_valid && bus.m_ready;

  // Completion is judged on the post-edge view so done lands the cycle after the last handshake.
  assign nothing_to_issue = !en || bus.fifo_empty ||
                            ((state == BURST) && (issue_cnt == 8'd0));
  assign buf_drains       = (buf_count == 2'd0) || ((buf_count == 2'd1) && pop);
  assign finish           = active && !rd && !inflight && nothing_to_issue && buf_drains;

  drain_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.fifo_rd_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (buf_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= 8'd0;
      inflight   <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= rd;
      if (pop) begin
        words_sent <= words_sent + DRAIN_CNT_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (en && flush) begin
            state <= FLUSH;
          end else if (en && bus.fifo_thr_trig) begin
            state     <= BURST;
            issue_cnt <= 8'(BURST_LEN);
          end
        end
        BURST, FLUSH: begin
          if (rd && (state == BURST)) begin
            issue_cnt <= issue_cnt - 8'd1;
          end
          if (finish) begin
            state     <= IDLE;
            issue_cnt <= 8'd0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
